parking_gate_controller: RTL and testbench
==========================================

# parking_gate_controller

Sequences access to the car-park occupancy counter for several entry and exit barriers. Arbitrates gate requests round-robin and opens one barrier at a time. Waits for the car-passed sensor, then issues a single-cycle `carIn`/`carOut` pulse to the occupancy counter. Sits between the gate hardware (request buttons, pass sensors, barrier drives) and the counter that produces `Full` and `count`.

## Interface
- `N_ENTRY`, default 2: number of entry gates, indices 0..N_ENTRY-1.
- `N_EXIT`, default 2: number of exit gates, indices N_ENTRY..N_ENTRY+N_EXIT-1.
- `TIMEOUT`, default 16: maximum OPEN cycles waiting for the pass sensor; must be ≥1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req` in N_ENTRY+N_EXIT: level request per gate, held until served.
- `pass` in N_ENTRY+N_EXIT: car-passed sensor per gate; only the granted gate's bit is observed.
- `Full` in 1: from the occupancy counter.
- `count` in 8: occupancy from the counter.
- `err_clr` in 1: clears `timeout_err`.
- `gate_open` out N_ENTRY+N_EXIT: barrier drive, at most one bit set.
- `carIn` out 1: one-cycle pulse to the counter, entry completed.
- `carOut` out 1: one-cycle pulse to the counter, exit completed.
- `busy` out 1: high whenever state ≠ IDLE.
- `timeout_err` out 1: sticky, set on a pass timeout.

## Operation
- States: IDLE, OPEN, DONE.
- **IDLE**
  - Eligible requests are entry `req` masked by `~Full`, plus exit `req` masked by `count != 0`.
  - If any request is eligible, the round-robin arbiter picks one gate; go to OPEN, latch the grant index and clear the timer.
  - Otherwise stay in IDLE.
- **OPEN**
  - `gate_open[grant]` = 1 and the timer increments each cycle.
  - `pass[grant]` = 1: go to DONE with the completion flag set.
  - Timer reaches TIMEOUT-1 with no pass: go to DONE with no completion and set `timeout_err`.
  - `req` deasserting during OPEN is ignored.
- **DONE**
  - `gate_open` = 0.
  - If the completion flag is set, pulse `carIn` (entry gate) or `carOut` (exit gate) for exactly this cycle.
  - Always go to IDLE next.
  - `carIn` and `carOut` are never high together.
- **Round-robin**
  - The search starts at the index after the last granted gate and wraps at N_ENTRY+N_EXIT-1 → 0.
  - The pointer updates only on grant.
  - Reset pointer: search starts at index 0.
- **Errors**
  - `timeout_err` is set in the cycle OPEN→DONE on timeout.
  - `err_clr` clears it; a set in the same cycle as `err_clr` wins.
- **Reset**
  - State IDLE; `gate_open`, `carIn`, `carOut`, `busy`, `timeout_err` all 0; pointer 0; timer 0.
  - Reset mid-OPEN closes the barrier immediately and emits no pulse.
- **Width rules**
  - Timer width is $clog2(TIMEOUT+1).
  - The `count != 0` test uses all 8 bits.
  - The controller never changes `count` itself.

## Timing
- Request seen in IDLE at edge k → `gate_open` high from edge k+1. `busy` goes high at the same edge.
- `pass[grant]` high at edge m → `gate_open` low and `carIn`/`carOut` high from edge m+1 for one cycle. The next IDLE cycle starts at edge m+2.
- The counter updates on the pulse, so `Full` and `count` are fresh when IDLE re-arbitrates. Minimum gap between grants is 3 cycles.
- Timeout: `gate_open` is high for exactly TIMEOUT cycles, then DONE with no pulse.
- `pass` asserted on the same edge as entering OPEN is not sampled; it is sampled from the first OPEN cycle onward.
- All outputs are registered; none is combinational from an input.

## Structure
- `parking_pkg` holds:
  - the state enum `{IDLE, OPEN, DONE}`;
  - the default N_ENTRY/N_EXIT/TIMEOUT constants;
  - the 8-bit count width constant shared with the occupancy counter.
- Sub-module `rr_arbiter`: generic N-way round-robin with `req`, `grant_en`, one-hot `grant` and an internal pointer. Instantiated once.
- The top holds the FSM, timer, grant latch, and pulse/error registers.

## Test plan
- Reset: assert `reset` async mid-cycle → all outputs 0 immediately; release, idle 5 cycles → `busy`=0.
- Single entry: `req[0]`=1, `pass[0]` three cycles after `gate_open[0]` rises → `gate_open[0]` high 3 cycles, then `carIn` = 1 for one cycle and `carOut`=0 throughout.
- Round-robin: `req`=4'b1111 held, `pass` tied high → grants in order 0,1,2,3,0, each separated by 3 cycles.
- Full/empty masking:
  - `Full`=1, `req`=4'b0001 → no grant; drop `Full` → grant 0 within 1 cycle.
  - `count`=0, `req`=4'b0100 → no grant.
- Timeout: TIMEOUT=16, `req[3]`=1, `pass`=0 → `gate_open[3]` high 16 cycles, no `carOut`, `timeout_err`=1. Pulse `err_clr` → 0.
- Reset during OPEN: after grant of gate 1, assert `reset` → `gate_open`=0, no `carIn`/`carOut`. After release, the first grant goes to the lowest requesting index from 0.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking gate controller and its occupancy counter.
package parking_pkg;

  localparam int unsigned DEF_N_ENTRY = 2;
  localparam int unsigned DEF_N_EXIT  = 2;
  localparam int unsigned DEF_TIMEOUT = 16;
  localparam int unsigned COUNT_W     = 8;

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    DONE
  } state_t;

endpackage

// File: rtl/parking_gate_controller_rr_arbiter.sv
// Generic N-way round-robin arbiter; the search starts one past the last granted index.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         grant_en,
  output logic [N-1:0] grant
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr;
  logic [IW-1:0] gidx;
  logic          found;

  // First requester at or after the pointer, wrapping at N-1 -> 0.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      if (!found && req[IW'((32'(ptr) + off) % N)]) begin
        found = 1'b1;
        gidx  = IW'((32'(ptr) + off) % N);
      end
    end
    if (found) grant[gidx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (grant_en && found) begin
      ptr <= (32'(gidx) + 32'd1 == N) ? '0 : gidx + IW'(1);
    end
  end

endmodule

// File: rtl/parking_gate_controller.sv
// Serialises entry/exit barrier requests onto one occupancy counter: grant, open, wait for pass, pulse.
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int unsigned N_ENTRY = DEF_N_ENTRY,
  parameter int unsigned N_EXIT  = DEF_N_EXIT,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_ENTRY+N_EXIT-1:0]   req,
  input  logic [N_ENTRY+N_EXIT-1:0]   pass,
  input  logic                        Full,
  input  logic [COUNT_W-1:0]          count,
  input  logic                        err_clr,
  output logic [N_ENTRY+N_EXIT-1:0]   gate_open,
  output logic                        carIn,
  output logic                        carOut,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int unsigned NG = N_ENTRY + N_EXIT;
  localparam int unsigned IW = (NG > 1) ? $clog2(NG) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] grant_sel;
  logic [TW-1:0] timer;
  logic [NG-1:0] eligible;
  logic [NG-1:0] grant;

  // Entries need free space, exits need at least one car inside.
  assign eligible = req & {{N_EXIT{count != '0}}, {N_ENTRY{~Full}}};

  rr_arbiter #(.N(NG)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (eligible),
    .grant_en (state == IDLE),
    .grant    (grant)
  );

  always_comb begin
    grant_sel = '0;
    for (int unsigned i = 0; i < NG; i++) begin
      if (grant[i]) grant_sel = IW'(i);
    end
  end

  // Gate sequencing FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant_idx   <= '0;
      timer       <= '0;
      gate_open   <= '0;
      carIn       <= 1'b0;
      carOut      <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      carIn  <= 1'b0;
      carOut <= 1'b0;
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (|eligible) begin
            state     <= OPEN;
            grant_idx <= grant_sel;
            gate_open <= grant;
            timer     <= '0;
            busy      <= 1'b1;
          end
        end
        OPEN: begin
          if (pass[grant_idx]) begin
            state     <= DONE;
            gate_open <= '0;
            if (32'(grant_idx) < N_ENTRY) carIn  <= 1'b1;
            else                          carOut <= 1'b1;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            state       <= DONE;
            gate_open   <= '0;
            timeout_err <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          gate_open <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Scoreboard bench: expected gate sessions are queued with the stimulus, a negedge monitor checks each one as it closes.
module tb_parking_gate_controller;

  localparam int unsigned NG = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] pass;
  logic       Full;
  logic [7:0] count;
  logic       err_clr;
  logic [3:0] gate_open;
  logic       carIn;
  logic       carOut;
  logic       busy;
  logic       timeout_err;

  typedef struct {
    logic [3:0] gate;
    int         len;
    logic       cin;
    logic       cout;
    int         gap;   // 0 = spacing not checked
  } txn_t;

  txn_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  parking_gate_controller #(.N_ENTRY(2), .N_EXIT(2), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .pass        (pass),
    .Full        (Full),
    .count       (count),
    .err_clr     (err_clr),
    .gate_open   (gate_open),
    .carIn       (carIn),
    .carOut      (carOut),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [3:0] g, input int len, input logic ci, input logic co, input int gap);
    txn_t t;
    t.gate = g; t.len = len; t.cin = ci; t.cout = co; t.gap = gap;
    exp_q.push_back(t);
  endtask

  task automatic wait_open();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (gate_open != '0) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL wait_open: gate_open stayed 0 for 50 cycles, expected a grant");
    end
  endtask

  // Monitor: one transaction per barrier session, closed when gate_open falls.
  int         cyc = 0;
  int         last_rise = 0;
  int         open_len = 0;
  int         gap = 0;
  logic [3:0] cur_gate = '0;
  logic [3:0] prev_open = '0;
  bit         chk_next = 1'b0;

  always @(negedge clk) begin
    txn_t e;
    cyc++;
    if (chk_next) begin
      chk_next = 1'b0;
      tests++;
      if (carIn || carOut) begin
        fails++;
        $display("FAIL pulse_width: carIn=%0b carOut=%0b one cycle after close, expected 0 0", carIn, carOut);
      end
    end
    if (gate_open != '0) begin
      if (prev_open == '0) begin
        gap       = cyc - last_rise;
        last_rise = cyc;
        open_len  = 0;
        cur_gate  = gate_open;
      end
      open_len++;
    end else if (prev_open != '0) begin
      chk_next = 1'b1;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL session: unexpected gate=%b len=%0d carIn=%0b carOut=%0b", cur_gate, open_len, carIn, carOut);
      end else begin
        e = exp_q.pop_front();
        if (cur_gate !== e.gate || open_len != e.len || carIn !== e.cin || carOut !== e.cout ||
            (e.gap != 0 && gap != e.gap)) begin
          fails++;
          $display("FAIL session: got gate=%b len=%0d in=%0b out=%0b gap=%0d expected gate=%b len=%0d in=%0b out=%0b gap=%0d",
                   cur_gate, open_len, carIn, carOut, gap, e.gate, e.len, e.cin, e.cout, e.gap);
        end
      end
    end
    prev_open = gate_open;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = '0; pass = '0; Full = 1'b0; count = 8'd5; err_clr = 1'b0;
    tick(1);
    check("reset_outputs", {gate_open, carIn, carOut, busy, timeout_err}, '0);
    reset = 1'b0;
    tick(5);
    check("idle_busy", {busy, gate_open}, '0);

    // Single entry, barrier held 3 cycles
    push(4'b0001, 3, 1'b1, 1'b0, 0);
    req = 4'b0001;
    wait_open();
    check("entry_busy", busy, 1'b1);
    tick(2);
    pass = 4'b0001; req = '0;
    tick(1);
    pass = '0;
    tick(3);

    // Round-robin from a fresh pointer
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    push(4'b0001, 1, 1'b1, 1'b0, 0);
    push(4'b0010, 1, 1'b1, 1'b0, 3);
    push(4'b0100, 1, 1'b0, 1'b1, 3);
    push(4'b1000, 1, 1'b0, 1'b1, 3);
    push(4'b0001, 1, 1'b1, 1'b0, 3);
    req = 4'b1111; pass = 4'b1111;
    wait_open();
    tick(12);
    check("rr_fifth_grant", gate_open, 4'b0001);
    req = '0;
    tick(3);
    pass = '0;
    tick(2);

    // Full masks entries
    Full = 1'b1; req = 4'b0001;
    tick(5);
    check("full_no_grant", {busy, gate_open}, '0);
    push(4'b0001, 1, 1'b1, 1'b0, 0);
    Full = 1'b0;
    tick(1);
    check("full_release_grant", gate_open, 4'b0001);
    pass = 4'b0001; req = '0;
    tick(3);
    pass = '0;

    // Empty lot masks exits
    count = 8'd0; req = 4'b0100;
    tick(5);
    check("empty_no_grant", {busy, gate_open}, '0);
    req = '0; count = 8'd5;
    tick(2);

    // Pass timeout on exit gate 3
    push(4'b1000, 16, 1'b0, 1'b0, 0);
    req = 4'b1000;
    wait_open();
    req = '0;
    tick(20);
    check("timeout_err_set", timeout_err, 1'b1);
    check("timeout_idle", busy, 1'b0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("timeout_err_clr", timeout_err, 1'b0);

    // Async reset while gate 1 is open
    push(4'b0010, 2, 1'b0, 1'b0, 0);
    req = 4'b0010;
    wait_open();
    tick(1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("reset_mid_open", {gate_open, carIn, carOut, busy, timeout_err}, '0);
    tick(2);
    push(4'b0010, 1, 1'b1, 1'b0, 0);
    reset = 1'b0; req = 4'b0110; pass = 4'b0110;
    wait_open();
    req = '0;
    tick(3);
    pass = '0;
    tick(5);

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
